// File: rtl/load_store_unit.sv
// Load/store unit: runs one decoded RV32I load or store as a single
// request/acknowledge transfer on a 32-bit word-addressed data bus.
// It steers byte lanes and write strobes, rejects misaligned or illegal
// accesses, aborts on a bus timeout and sign/zero-extends load data.
//
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   start                      one-cycle request strobe (sampled in IDLE only)
//   data_r, data_w             decoded load / store
//   data_size                  00 byte, 01 half, 10 word, 11 illegal
//   unsigned_value             zero-extend load data (LBU/LHU)
//   addr, wdata                byte address, store data
//   busy, done, err            status; done/err are one-cycle pulses
//   rdata                      extended load result, held until next load
//   bus_req/we/addr/wdata/wstrb  data bus request side
//   bus_ack, bus_rdata         data bus response side
module load_store_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        data_r,
    input  logic        data_w,
    input  logic [1:0]  data_size,
    input  logic        unsigned_value,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [31:0] rdata,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_wstrb,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata
);

    localparam int unsigned CNT_W = 16;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_REQ  = 2'b01,
        S_FIN  = 2'b10
    } state_t;

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [1:0]       size_q, size_n;
    logic             uns_q, uns_n;
    logic [1:0]       off_q, off_n;

    logic        busy_n, done_n, err_n;
    logic [31:0] rdata_n;
    logic        req_n, we_n;
    logic [31:0] addr_n, wdata_n;
    logic [3:0]  wstrb_n;

    logic        misaligned, bad_req;
    logic [3:0]  st_strb;
    logic [31:0] st_data;
    logic [31:0] rd_shift, ld_ext;

    // Request legality, evaluated on the live decoder inputs
    always_comb begin
        misaligned = ((data_size == 2'b01) && addr[0]) ||
                     ((data_size == 2'b10) && (addr[1:0] != 2'b00));
        bad_req    = (data_r && data_w) || (data_size == 2'b11) || misaligned;
    end

    // Store lane replication and byte enables
    always_comb begin
        st_strb = 4'b1111;
        st_data = wdata;
        case (data_size)
            2'b00: begin
                st_strb = 4'b0001 << addr[1:0];
                st_data = {4{wdata[7:0]}};
            end
            2'b01: begin
                st_strb = 4'b0011 << addr[1:0];
                st_data = {2{wdata[15:0]}};
            end
            default: ;
        endcase
    end

    // Load lane extraction and extension using the latched lane/size
    always_comb begin
        rd_shift = bus_rdata >> {off_q, 3'b000};
        case (size_q)
            2'b00:   ld_ext = uns_q ? {24'h0, rd_shift[7:0]}
                                    : {{24{rd_shift[7]}}, rd_shift[7:0]};
            2'b01:   ld_ext = uns_q ? {16'h0, rd_shift[15:0]}
                                    : {{16{rd_shift[15]}}, rd_shift[15:0]};
            default: ld_ext = bus_rdata;
        endcase
    end

    // Next-state and next-output logic
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        size_n  = size_q;
        uns_n   = uns_q;
        off_n   = off_q;
        busy_n  = busy;
        done_n  = 1'b0;
        err_n   = 1'b0;
        rdata_n = rdata;
        req_n   = bus_req;
        we_n    = bus_we;
        addr_n  = bus_addr;
        wdata_n = bus_wdata;
        wstrb_n = bus_wstrb;

        case (state)
            S_IDLE: begin
                if (start) begin
                    busy_n = 1'b1;
                    if (bad_req) begin
                        state_n = S_FIN;
                        done_n  = 1'b1;
                        err_n   = 1'b1;
                    end else if (!data_r && !data_w) begin
                        state_n = S_FIN;
                        done_n  = 1'b1;
                    end else begin
                        state_n = S_REQ;
                        cnt_n   = '0;
                        size_n  = data_size;
                        uns_n   = unsigned_value;
                        off_n   = addr[1:0];
                        req_n   = 1'b1;
                        we_n    = data_w;
                        addr_n  = {addr[31:2], 2'b00};
                        wdata_n = data_w ? st_data : bus_wdata;
                        wstrb_n = data_w ? st_strb : 4'b0000;
                    end
                end
            end
            S_REQ: begin
                // An ack in the final allowed cycle still wins over the timeout
                if (bus_ack) begin
                    state_n = S_FIN;
                    done_n  = 1'b1;
                    req_n   = 1'b0;
                    we_n    = 1'b0;
                    wstrb_n = 4'b0000;
                    if (!bus_we) begin
                        rdata_n = ld_ext;
                    end
                end else if (cnt == CNT_LAST) begin
                    state_n = S_FIN;
                    done_n  = 1'b1;
                    err_n   = 1'b1;
                    req_n   = 1'b0;
                    we_n    = 1'b0;
                    wstrb_n = 4'b0000;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            S_FIN: begin
                state_n = S_IDLE;
                busy_n  = 1'b0;
            end
            default: begin
                state_n = S_IDLE;
                busy_n  = 1'b0;
                req_n   = 1'b0;
                we_n    = 1'b0;
                wstrb_n = 4'b0000;
            end
        endcase
    end

    // State and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            cnt       <= '0;
            size_q    <= 2'b00;
            uns_q     <= 1'b0;
            off_q     <= 2'b00;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            rdata     <= '0;
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= '0;
            bus_wdata <= '0;
            bus_wstrb <= 4'b0000;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            size_q    <= size_n;
            uns_q     <= uns_n;
            off_q     <= off_n;
            busy      <= busy_n;
            done      <= done_n;
            err       <= err_n;
            rdata     <= rdata_n;
            bus_req   <= req_n;
            bus_we    <= we_n;
            bus_addr  <= addr_n;
            bus_wdata <= wdata_n;
            bus_wstrb <= wstrb_n;
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit (TIMEOUT_CYCLES = 4): a vector table
// of single transactions with a simple bus responder, followed by
// hand-written sequences for late ack, ignored start and mid-access reset.
module tb_load_store_unit;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        data_r;
    logic        data_w;
    logic [1:0]  data_size;
    logic        unsigned_value;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic        err;
    logic [31:0] rdata;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_wstrb;
    logic        bus_ack;
    logic [31:0] bus_rdata;

    int pass_cnt;
    int total_cnt;

    load_store_unit #(.TIMEOUT_CYCLES(4)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .data_r         (data_r),
        .data_w         (data_w),
        .data_size      (data_size),
        .unsigned_value (unsigned_value),
        .addr           (addr),
        .wdata          (wdata),
        .busy           (busy),
        .done           (done),
        .err            (err),
        .rdata          (rdata),
        .bus_req        (bus_req),
        .bus_we         (bus_we),
        .bus_addr       (bus_addr),
        .bus_wdata      (bus_wdata),
        .bus_wstrb      (bus_wstrb),
        .bus_ack        (bus_ack),
        .bus_rdata      (bus_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        r;
        logic        w;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] a;
        logic [31:0] wd;
        logic [31:0] brd;
        int          wt;      // REQ cycles before ack; large = never
        logic        e_err;
        int          e_lat;   // cycle of done, start at cycle 0
        int          e_req;   // cycles with bus_req high
        logic [31:0] e_baddr;
        logic [3:0]  e_strb;
        logic [31:0] e_bwdata;
        logic [31:0] e_rdata;
    } vec_t;

    vec_t vecs[$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(
        input string n, input logic r, input logic w, input logic [1:0] sz,
        input logic u, input logic [31:0] a, input logic [31:0] wd,
        input logic [31:0] brd, input int wt, input logic ee, input int lat,
        input int rq, input logic [31:0] ba, input logic [3:0] st,
        input logic [31:0] bwd, input logic [31:0] erd);
        vec_t v;
        v.name = n; v.r = r; v.w = w; v.size = sz; v.uns = u; v.a = a;
        v.wd = wd; v.brd = brd; v.wt = wt; v.e_err = ee; v.e_lat = lat;
        v.e_req = rq; v.e_baddr = ba; v.e_strb = st; v.e_bwdata = bwd;
        v.e_rdata = erd;
        return v;
    endfunction

    // Issue one start in the current cycle, act as bus responder, and
    // return in the cycle after done (so the next call is back-to-back).
    task automatic run(input vec_t v);
        int req_cnt;
        int done_cyc;
        req_cnt  = 0;
        done_cyc = -1;
        chk({v.name, "_busy_idle"}, 32'(busy), 32'(0));
        data_r         = v.r;
        data_w         = v.w;
        data_size      = v.size;
        unsigned_value = v.uns;
        addr           = v.a;
        wdata          = v.wd;
        start          = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            if (c == 1) chk({v.name, "_busy"}, 32'(busy), 32'(1));
            if (bus_req) begin
                req_cnt++;
                if (req_cnt == 1) begin
                    chk({v.name, "_baddr"}, bus_addr, v.e_baddr);
                    chk({v.name, "_we"}, 32'(bus_we), 32'(v.w));
                    chk({v.name, "_wstrb"}, 32'(bus_wstrb), 32'(v.e_strb));
                    if (v.w) chk({v.name, "_bwdata"}, bus_wdata, v.e_bwdata);
                end
                if (c == 1 + v.wt) begin
                    bus_ack   = 1'b1;
                    bus_rdata = v.brd;
                end
            end
            if (done) begin
                done_cyc = c;
                chk({v.name, "_err"}, 32'(err), 32'(v.e_err));
                chk({v.name, "_rdata"}, rdata, v.e_rdata);
                chk({v.name, "_busy_done"}, 32'(busy), 32'(1));
                chk({v.name, "_we_after"}, {27'(0), bus_wstrb, bus_we}, 32'(0));
                tick();
                bus_ack = 1'b0;
                break;
            end
            tick();
            bus_ack = 1'b0;
        end
        chk({v.name, "_latency"}, 32'(done_cyc), 32'(v.e_lat));
        chk({v.name, "_req_cycles"}, 32'(req_cnt), 32'(v.e_req));
    endtask

    initial begin
        logic bad;
        pass_cnt       = 0;
        total_cnt      = 0;
        rst_n          = 1'b0;
        start          = 1'b0;
        data_r         = 1'b0;
        data_w         = 1'b0;
        data_size      = 2'b00;
        unsigned_value = 1'b0;
        addr           = '0;
        wdata          = '0;
        bus_ack        = 1'b0;
        bus_rdata      = '0;

        // name r w size u addr wdata bus_rdata wait | err lat req baddr strb bwdata rdata
        vecs.push_back(mk("sb_1003",  0,1,2'b00,0,32'h1003,32'h000000A5,32'h0,       0, 0,2,1,32'h1000,4'b1000,32'hA5A5A5A5,32'h0));
        vecs.push_back(mk("lh_2002",  1,0,2'b01,0,32'h2002,32'h0,       32'h80011234,3, 0,5,4,32'h2000,4'b0000,32'h0,       32'hFFFF8001));
        vecs.push_back(mk("lhu_2002", 1,0,2'b01,1,32'h2002,32'h0,       32'h80011234,3, 0,5,4,32'h2000,4'b0000,32'h0,       32'h00008001));
        vecs.push_back(mk("lw_mis",   1,0,2'b10,0,32'h0001,32'h0,       32'h0,       0, 1,1,0,32'h0,   4'b0000,32'h0,       32'h00008001));
        vecs.push_back(mk("sh_mis",   0,1,2'b01,0,32'h0003,32'h1234,    32'h0,       0, 1,1,0,32'h0,   4'b0000,32'h0,       32'h00008001));
        vecs.push_back(mk("lb_0101",  1,0,2'b00,0,32'h0101,32'h0,       32'h1234F678,1, 0,3,2,32'h0100,4'b0000,32'h0,       32'hFFFFFFF6));
        vecs.push_back(mk("lbu_0103", 1,0,2'b00,1,32'h0103,32'h0,       32'h9A345678,0, 0,2,1,32'h0100,4'b0000,32'h0,       32'h0000009A));
        vecs.push_back(mk("lw_uns",   1,0,2'b10,1,32'h0010,32'h0,       32'h80000001,0, 0,2,1,32'h0010,4'b0000,32'h0,       32'h80000001));
        vecs.push_back(mk("sh_2002",  0,1,2'b01,0,32'h2002,32'hFFFFBEEF,32'h0,       2, 0,4,3,32'h2000,4'b1100,32'hBEEFBEEF,32'h80000001));
        vecs.push_back(mk("sw_3000",  0,1,2'b10,0,32'h3000,32'h12345678,32'h0,       0, 0,2,1,32'h3000,4'b1111,32'h12345678,32'h80000001));
        vecs.push_back(mk("sb_3001",  0,1,2'b00,0,32'h3001,32'h0000003C,32'h0,       0, 0,2,1,32'h3000,4'b0010,32'h3C3C3C3C,32'h80000001));
        vecs.push_back(mk("noop",     0,0,2'b00,0,32'h0000,32'h0,       32'h0,       0, 0,1,0,32'h0,   4'b0000,32'h0,       32'h80000001));
        vecs.push_back(mk("rw_both",  1,1,2'b10,0,32'h0004,32'h0,       32'h0,       0, 1,1,0,32'h0,   4'b0000,32'h0,       32'h80000001));
        vecs.push_back(mk("size11",   1,0,2'b11,0,32'h0000,32'h0,       32'h0,       0, 1,1,0,32'h0,   4'b0000,32'h0,       32'h80000001));
        vecs.push_back(mk("lh_0000",  1,0,2'b01,0,32'h0000,32'h0,       32'h00007FFF,0, 0,2,1,32'h0000,4'b0000,32'h0,       32'h00007FFF));
        vecs.push_back(mk("lw_tmo",   1,0,2'b10,0,32'h0040,32'h0,       32'h0,       99,1,5,4,32'h0040,4'b0000,32'h0,       32'h00007FFF));

        tick();
        tick();
        #2 rst_n = 1'b1;
        tick();

        // Reset state
        chk("rst_busy_done_err", {29'(0), busy, done, err}, 32'(0));
        chk("rst_req_we_strb", {26'(0), bus_req, bus_we, bus_wstrb}, 32'(0));
        chk("rst_bus_addr", bus_addr, 32'h0);
        chk("rst_bus_wdata", bus_wdata, 32'h0);
        chk("rst_rdata", rdata, 32'h0);

        foreach (vecs[i]) run(vecs[i]);

        // A late ack after the timeout must not produce a completion
        bad = 1'b0;
        bus_ack   = 1'b1;
        bus_rdata = 32'hCAFEF00D;
        for (int c = 0; c < 3; c++) begin
            if (done || bus_req) bad = 1'b1;
            tick();
        end
        bus_ack = 1'b0;
        chk("late_ack_quiet", 32'(bad), 32'(0));
        chk("late_ack_rdata", rdata, 32'h00007FFF);

        // start held through REQ and pulsed in FIN is ignored
        data_r = 1'b1; data_w = 1'b0; data_size = 2'b10; unsigned_value = 1'b0;
        addr = 32'h20;
        start = 1'b1;
        tick();                               // cycle 1, REQ, start still high
        chk("ign_req1", 32'(bus_req), 32'(1));
        tick();                               // cycle 2
        start = 1'b0;
        bus_ack = 1'b1;
        bus_rdata = 32'h11111111;
        tick();                               // cycle 3, FIN
        bus_ack = 1'b0;
        chk("ign_done", 32'(done), 32'(1));
        chk("ign_rdata", rdata, 32'h11111111);
        start = 1'b1;
        tick();
        start = 1'b0;
        bad = 1'b0;
        for (int c = 0; c < 5; c++) begin
            if (done || bus_req || busy) bad = 1'b1;
            tick();
        end
        chk("ign_no_second", 32'(bad), 32'(0));

        // Reset in the middle of REQ
        data_r = 1'b1; data_w = 1'b0; data_size = 2'b10; addr = 32'h50;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        chk("mid_rst_req_before", 32'(bus_req), 32'(1));
        rst_n = 1'b0;
        #1;
        chk("mid_rst_req_async", 32'(bus_req), 32'(0));
        chk("mid_rst_busy_async", 32'(busy), 32'(0));
        bad = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            if (done || bus_req) bad = 1'b1;
        end
        chk("mid_rst_no_done", 32'(bad), 32'(0));
        #2 rst_n = 1'b1;
        tick();
        run(mk("lw_after_rst", 1,0,2'b10,0,32'h0010,32'h0,32'hDEADBEEF,0, 0,2,1,32'h0010,4'b0000,32'h0,32'hDEADBEEF));

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    // Absolute time bound so the run always ends
    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Executes the memory access that the RV32I instruction decoder requests through its data_r, data_w, data_size and unsigned_value controls.
- Turns one decoded load or store into a single request/acknowledge transaction on a 32-bit word-addressed data bus. Handles byte-lane steering, write strobes, misalignment detection, a bus timeout, and sign/zero extension of load data.
- Sits between the execute stage (address from the ALU, store data from rs2) and the register-file write-back mux (rd_data_sel = 01).

Parameters:
- TIMEOUT_CYCLES, 255: maximum cycles to wait for bus_ack before aborting with err (1..65535).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  one-cycle request strobe, sampled only in IDLE.
- data_r  in  1  decoded load.
- data_w  in  1  decoded store.
- data_size  in  2  00 byte, 01 half, 10 word, 11 illegal.
- unsigned_value  in  1  zero-extend load data (LBU/LHU).
- addr  in  32  byte address from the ALU.
- wdata  in  32  store data (rs2).
- busy  out  1  high from the cycle after start until the cycle done pulses, inclusive.
- done  out  1  one-cycle completion pulse.
- err  out  1  one-cycle pulse, coincident with done, on a failed access.
- rdata  out  32  extended load result, valid with done and held until the next load completes.
- bus_req  out  1  bus request, held until ack or timeout.
- bus_we  out  1  1 = write.
- bus_addr  out  32  {addr[31:2], 2'b00}.
- bus_wdata  out  32  lane-replicated store data.
- bus_wstrb  out  4  byte enables; 0000 on reads.
- bus_ack  in  1  responder acknowledge; completes the transfer in the cycle it is sampled high with bus_req high.
- bus_rdata  in  32  read word, valid with bus_ack.

Behaviour:
- Reset (async assert, sync deassert by the registering logic): state IDLE. busy, done, err, bus_req, bus_we = 0. bus_addr, bus_wdata, rdata = 0. bus_wstrb = 0000. Timeout counter = 0.
- States:
  - IDLE: wait for start.
  - REQ: bus_req=1, wait for ack.
  - FIN: single cycle; done=1, error flag already registered.
- Transitions out of IDLE on start:
  - Legal request (exactly one of data_r/data_w, aligned, size != 11): latch address, size, unsigned flag, lane and data; go to REQ. bus_req rises the next cycle.
  - Both data_r and data_w set, size = 11, or misaligned (half with addr[0]=1; word with addr[1:0] != 0): go to FIN with err=1. No bus activity.
  - Neither data_r nor data_w set: go to FIN with err=0. rdata unchanged.
- REQ:
  - bus_ack=1: capture bus_rdata, go to FIN with err=0.
  - Counter reaches TIMEOUT_CYCLES without ack: drop bus_req, go to FIN with err=1, rdata unchanged.
  - Counter clears on entry to REQ.
- FIN: done=1 (and err if flagged), then IDLE.
- start while not IDLE: ignored, never queued.
- Latency: start at cycle 0, bus_req at cycle 1. Ack sampled at cycle k gives done at k+1. Zero-wait ack gives done at cycle 2. Error/no-op paths give done at cycle 1.
- Write lanes (o = addr[1:0]):
  - byte: wstrb = 0001<<o, wdata = {4{wdata[7:0]}}.
  - half: wstrb = 0011<<o, wdata = {2{wdata[15:0]}}.
  - word: wstrb = 1111, wdata = wdata.
- Read extraction:
  - byte = bus_rdata[8*o+7 : 8*o]; half = bus_rdata[8*o+15 : 8*o].
  - Sign-extend unless unsigned_value; word passes through and unsigned_value is ignored.
- Bus outputs are stable while bus_req=1. bus_we and bus_wstrb return to 0 in the cycle after completion.
- rst_n asserted mid-transaction: bus_req drops immediately (asynchronously). No done pulse; the access is lost.

Test Plan:
- Store byte: start, data_w=1, size=00, addr=0x1003, wdata=0x000000A5, ack on 1st REQ cycle -> bus_addr=0x1000, wstrb=1000, bus_wdata=0xA5A5A5A5, done at cycle 2, err=0.
- Load half signed vs unsigned: addr=0x2002, bus_rdata=0x8001_1234 with ack after 3 wait cycles -> rdata=0xFFFF8001 with unsigned_value=0, rdata=0x00008001 with unsigned_value=1; done 1 cycle after ack.
- Misaligned: LW addr=0x0001; SH addr=0x0003 -> bus_req never rises, done+err pulse at cycle 1, rdata unchanged.
- Timeout: TIMEOUT_CYCLES=4, load with bus_ack held 0 -> bus_req high exactly 4 cycles, then done+err. A late bus_ack is ignored.
- start pulsed in REQ and in FIN -> no second transaction. Back-to-back start the cycle after done -> accepted.
- rst_n pulled low during REQ -> bus_req=0, busy=0, no done. After release, a new LW addr=0x10 with bus_rdata=0xDEADBEEF gives rdata=0xDEADBEEF.
